// File: rtl/dequantize_stream_pkg.sv
// Shared constants and types for the receive-side dequantizer.
// QU matches the transmit quantizer divisor.
package dequantize_stream_pkg;

    localparam int N_DEF     = 16;
    localparam int LANE_W    = N_DEF / 2;
    localparam int QU_DEF    = 3;
    localparam int MAG_MAX   = 127;
    localparam int CNT_W_DEF = 16;
    localparam int PROD_W    = 11;

    typedef struct packed {
        logic              sign;
        logic [LANE_W-1:0] mag;
    } lane_sm_t;

    // -128 yields magnitude 0x80, read as unsigned 128.
    function automatic lane_sm_t to_sign_mag(input logic [LANE_W-1:0] x);
        lane_sm_t r;
        r.sign = x[LANE_W-1];
        r.mag  = x[LANE_W-1] ? (~x + LANE_W'(1)) : x;
        return r;
    endfunction

endpackage

// File: rtl/dequantize_stream_if.sv
// Valid/ready stream carrying packed {re, im} samples.
interface dequantize_stream_if #(
    parameter int N = 16
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dequantize_stream_lane.sv
// One lane of the rescaler: sign-magnitude in, |x|*QU clipped to 127, sign restored.
// The output range is symmetric, so -128 is never produced.
module dequant_lane
    import dequantize_stream_pkg::*;
#(
    parameter int QU = QU_DEF
) (
    input  lane_sm_t                 sm_i,
    output logic signed [LANE_W-1:0] lane_o,
    output logic                     sat_o
);

    function automatic logic [PROD_W-1:0] scale(input logic [LANE_W-1:0] mag);
        return PROD_W'(mag) * PROD_W'(QU);
    endfunction

    function automatic logic [LANE_W-1:0] sat_mag(input logic [PROD_W-1:0] prod);
        return (prod > PROD_W'(MAG_MAX)) ? LANE_W'(MAG_MAX) : prod[LANE_W-1:0];
    endfunction

    logic [PROD_W-1:0] prod;
    logic [LANE_W-1:0] res_mag;

    always_comb begin
        prod    = scale(sm_i.mag);
        sat_o   = (prod > PROD_W'(MAG_MAX));
        res_mag = sat_mag(prod);
        lane_o  = sm_i.sign ? -$signed(res_mag) : $signed(res_mag);
    end

endmodule

// File: rtl/dequantize_stream.sv
// Two-stage valid/ready dequantizer for packed complex samples, with a sticky
// count of output samples that clipped in either lane. N must equal 2*LANE_W.
module dequantize_stream
    import dequantize_stream_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int QU    = QU_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  clear_n_i,
    dequantize_stream_if.slave    in_if,
    dequantize_stream_if.master   out_if,
    input  logic                  cnt_clr_i,
    output logic [CNT_W-1:0]      sat_cnt_o
);

    localparam int LW = N / 2;

    logic s1_ready, s2_ready, out_fire;

    logic       vld_p1_q, vld_p1_d;
    lane_sm_t   re_p1_q, re_p1_d;
    lane_sm_t   im_p1_q, im_p1_d;

    logic         vld_p2_q, vld_p2_d;
    logic [N-1:0] data_p2_q, data_p2_d;
    logic         sat_p2_q, sat_p2_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic signed [LANE_W-1:0] re_out, im_out;
    logic                     re_sat, im_sat;

    // Ready chain: a stage may take new data if empty or draining this cycle.
    always_comb begin
        s2_ready = !vld_p2_q || out_if.ready;
        s1_ready = !vld_p1_q || s2_ready;
        out_fire = vld_p2_q && out_if.ready;
    end

    assign in_if.ready = s1_ready && clear_n_i;

    dequant_lane #(.QU(QU)) u_lane_re (
        .sm_i   (re_p1_q),
        .lane_o (re_out),
        .sat_o  (re_sat)
    );

    dequant_lane #(.QU(QU)) u_lane_im (
        .sm_i   (im_p1_q),
        .lane_o (im_out),
        .sat_o  (im_sat)
    );

    always_comb begin
        // S1: sign/magnitude capture
        vld_p1_d = vld_p1_q;
        re_p1_d  = re_p1_q;
        im_p1_d  = im_p1_q;
        if (s1_ready) begin
            vld_p1_d = in_if.valid;
        end
        if (s1_ready && in_if.valid) begin
            re_p1_d = to_sign_mag(in_if.data[N-1:LW]);
            im_p1_d = to_sign_mag(in_if.data[LW-1:0]);
        end

        // S2: scaled, clipped lanes
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        sat_p2_d  = sat_p2_q;
        if (s2_ready) begin
            vld_p2_d = vld_p1_q;
        end
        if (s2_ready && vld_p1_q) begin
            data_p2_d = {re_out, im_out};
            sat_p2_d  = re_sat || im_sat;
        end

        // Clear wins over a same-cycle increment; the count never wraps.
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (out_fire && sat_p2_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_n_i) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            sat_p2_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            sat_p2_q  <= sat_p2_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        re_p1_q <= re_p1_d;
        im_p1_q <= im_p1_d;
    end

    assign out_if.valid = vld_p2_q;
    assign out_if.data  = data_p2_q;
    assign sat_cnt_o    = cnt_q;

endmodule

// File: tb/tb_dequantize_stream.sv
// Scoreboard bench for dequantize_stream: driver pushes expected samples,
// a negedge monitor pops and compares outputs and the saturation count.
module tb_dequantize_stream;
    import dequantize_stream_pkg::*;

    localparam int QU    = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [15:0] data;
        bit          sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             clear_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] sat_cnt;

    dequantize_stream_if #(.N(16)) in_if ();
    dequantize_stream_if #(.N(16)) out_if ();

    dequantize_stream #(.N(16), .QU(QU), .CNT_W(CNT_W)) dut (
        .clk_i     (clk),
        .clear_n_i (clear_n),
        .in_if     (in_if),
        .out_if    (out_if),
        .cnt_clr_i (cnt_clr),
        .sat_cnt_o (sat_cnt)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    int          exp_cnt = 0;
    int          ready_mode = 1;
    bit          mon_en = 0;
    logic [15:0] smp [3];

    // Reference: plain integer arithmetic on signed lane values.
    function automatic int ref_lane(input int x, output bit sat);
        int m, p;
        m   = (x < 0) ? -x : x;
        p   = m * QU;
        sat = (p > 127);
        if (sat) p = 127;
        return (x < 0) ? -p : p;
    endfunction

    function automatic exp_t ref_sample(input logic [15:0] d);
        exp_t e;
        bit   s_re, s_im;
        int   re, im;
        re     = ref_lane(int'($signed(d[15:8])), s_re);
        im     = ref_lane(int'($signed(d[7:0])), s_im);
        e.data = {8'(re), 8'(im)};
        e.sat  = s_re | s_im;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_e(input logic [15:0] d, input exp_t e);
        int n;
        n = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        forever begin
            @(negedge clk);
            if (in_if.ready) break;
            n++;
            if (n > 200) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: in_ready 0 for 200 cycles, required 1");
                break;
            end
        end
        if (in_if.ready) sb.push_back(e);
        tick();
        in_if.valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        send_e(d, ref_sample(d));
    endtask

    task automatic send_x(input logic [15:0] d, input logic [15:0] exp_data, input bit sat);
        exp_t e;
        e.data = exp_data;
        e.sat  = sat;
        send_e(d, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", sb.size(), 0);
        tick();
    endtask

    // Downstream ready: forced low, forced high, or random per cycle.
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_if.ready = 1'b0;
                1:       out_if.ready = 1'b1;
                default: out_if.ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares outputs in FIFO order and tracks the expected count.
    initial begin
        bit          prev_hold;
        logic [15:0] prev_data;
        exp_t        e;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("sat_cnt", 32'(sat_cnt), exp_cnt);
                if (prev_hold) begin
                    check("hold_valid", out_if.valid, 1);
                    check("hold_data", out_if.data, prev_data);
                end
                prev_hold = out_if.valid && !out_if.ready && clear_n;
                prev_data = out_if.data;
                if (!clear_n) begin
                    sb.delete();
                    exp_cnt   = 0;
                    prev_hold = 1'b0;
                end else if (out_if.valid && out_if.ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_output: got 0x%0h, required no output", out_if.data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_if.data, e.data);
                        if (cnt_clr) exp_cnt = 0;
                        else if (e.sat && exp_cnt < CMAX) exp_cnt++;
                    end
                end else if (cnt_clr) begin
                    exp_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [15:0] d;
        clear_n     = 1'b0;
        cnt_clr     = 1'b0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        smp[0] = 16'h0101;
        smp[1] = 16'h0202;
        smp[2] = 16'h0303;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", in_if.ready, 0);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_data", out_if.data, 0);
        check("rst_sat_cnt", 32'(sat_cnt), 0);
        tick();
        clear_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_if.ready, 1);
        tick();

        // 1: basic scaling and two-cycle latency
        send_x(16'h0AF6, 16'h1EE2, 1'b0);
        check("lat_early_valid", out_if.valid, 0);
        tick();
        check("lat_2_valid", out_if.valid, 1);
        check("lat_2_data", out_if.data, 16'h1EE2);
        drain();

        // 2: largest unclipped and first clipped magnitude
        send_x(16'h2AD6, 16'h7E82, 1'b0);
        send_x(16'h2BD5, 16'h7F81, 1'b1);
        drain();
        check("t2_sat_cnt", 32'(sat_cnt), 1);

        // 3: -128 and zero
        send_x(16'h8000, 16'h8100, 1'b1);
        send_x(16'h0000, 16'h0000, 1'b0);
        drain();
        check("t3_sat_cnt", 32'(sat_cnt), 2);

        // 4: backpressure with three offered samples
        ready_mode = 0;
        tick();
        acc = 0;
        in_if.valid = 1'b1;
        in_if.data  = smp[0];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_if.ready && acc < 3) begin
                sb.push_back(ref_sample(smp[acc]));
                acc++;
            end
            tick();
            if (acc < 3) in_if.data = smp[acc];
            else in_if.valid = 1'b0;
        end
        check("bp_accepted", acc, 2);
        @(negedge clk);
        check("bp_in_ready", in_if.ready, 0);
        ready_mode = 1;
        send(smp[2]);
        drain();

        // 5: random stream with random downstream ready
        ready_mode = 2;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            d = 16'($urandom);
            send(d);
        end
        drain();
        ready_mode = 1;
        repeat (2) tick();
        check("t5_sat_cnt", 32'(sat_cnt), exp_cnt);

        // 6a: reset with two samples in flight
        send(16'h7F7F);
        send(16'h0101);
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        check("flight_out_valid", out_if.valid, 0);
        check("flight_sat_cnt", 32'(sat_cnt), 0);
        @(negedge clk);
        check("flight_in_ready", in_if.ready, 1);
        repeat (4) tick();

        // 6b: counter clear concurrent with a clipped sample
        send(16'h7F7F);
        drain();
        check("pre_clr_sat_cnt", 32'(sat_cnt), 1);
        cnt_clr = 1'b1;
        send(16'h7F7F);
        drain();
        check("clr_sat_cnt", 32'(sat_cnt), 0);
        cnt_clr = 1'b0;
        tick();
        check("clr_after_sat_cnt", 32'(sat_cnt), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
